ufm_burst_writer: RTL and testbench
===================================

Name: ufm_burst_writer

Overview:
- Parametrised successor to the fixed six-word UFM write sequencer.
- Programs NUM_WORDS 32-bit words into on-chip user flash through the Avalon-MM data port, starting at BASE_ADDR.
- Optionally unprotects and erases the target sector first; re-protects it at the end.
- Polls the CSR status register after every flash operation, checks the success bits, enforces a poll timeout, and reports done/error to the top-level control FSM.

Parameters:
- NUM_WORDS, 6, number of 32-bit words programmed per run (1..256).
- ADDR_W, 16, data-port word address width.
- BASE_ADDR, 0, address of the first word; word i goes to BASE_ADDR+i.
- ERASE_EN, 1, 1 = erase the sector before programming; 0 = skip erase.
- CTRL_OPEN, 32'hF7FFFFFF, CSR control value that unprotects the sector (erase field idle).
- CTRL_ERASE, 32'hF71FFFFF, CSR control value that unprotects the sector and starts its erase.
- CTRL_LOCK, 32'hFFFFFFFF, CSR control value that re-protects all sectors.
- POLL_TIMEOUT, 65535, maximum cycles spent in any single poll phase.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request; accepted only in IDLE, DONE or ERR
- data_words  in  NUM_WORDS*32  word i = bits [32i+31:32i]; captured on accepted start
- ufmwrite  out  1  Avalon data-port write
- write_addr  out  ADDR_W  data-port word address
- writedata  out  32  data-port write data
- waitrequest  in  1  data-port waitrequest
- csr_addr  out  1  0 = status register, 1 = control register
- csr_read  out  1  CSR read strobe
- csr_write  out  1  CSR write strobe
- csr_writedata  out  32  CSR write data
- csr_readdata  in  32  CSR read data; valid exactly 1 cycle after csr_read
- busy  out  1  high from accepted start until DONE or ERR
- done  out  1  level; high in DONE
- error  out  1  level; high in ERR
- err_code  out  2  01 erase fail, 10 write fail, 11 poll timeout, 00 none
- words_written  out  9  count of words confirmed successful this run

Behaviour:
- Reset, synchronous: state IDLE; all strobes 0; busy/done/error 0; err_code 0; words_written 0; write_addr BASE_ADDR; writedata 0.
- Reset mid-run aborts immediately, including a data write held by waitrequest. After such an abort the caller waits for flash idle before the next start.
- States:
  - IDLE/DONE/ERR: on start, capture data_words, clear words_written, err_code, done and error, and set busy. Go to OPEN_WR, or ERASE_WR if ERASE_EN=1.
  - ERASE_WR: one cycle with csr_write=1, csr_addr=1, csr_writedata=CTRL_ERASE. Go to ERASE_POLL.
  - OPEN_WR: same as ERASE_WR but with CTRL_OPEN. Go to DATA_WR.
  - ERASE_POLL: repeat the poll cycle until status[1:0]==00.
    - Poll cycle: assert csr_read (csr_addr=0) for 1 cycle, sample csr_readdata on the next cycle, so one poll every 2 cycles.
    - On idle: status[4]=1 goes to OPEN_WR; status[4]=0 goes to ERR with err_code 01.
  - DATA_WR: ufmwrite=1 with write_addr=BASE_ADDR+idx and writedata=word idx.
    - Hold all three stable while waitrequest=1.
    - The first cycle with waitrequest=0 completes the transfer. Deassert ufmwrite next cycle and go to DATA_POLL.
  - DATA_POLL: poll as in ERASE_POLL.
    - On idle with status[3]=1: increment words_written.
    - If idx==NUM_WORDS-1, go to LOCK_WR; otherwise idx+1 and return to DATA_WR.
    - On idle with status[3]=0: go to LOCK_WR, then to ERR with err_code 10.
  - LOCK_WR: one csr_write of CTRL_LOCK to control, then DONE, or ERR if an error is pending.
- Timeout:
  - The counter clears on entry to each poll phase.
  - Reaching POLL_TIMEOUT cycles without idle sets err_code 11 and goes through LOCK_WR to ERR.
  - Timeout takes priority over a status sample in the same cycle.
- Exclusivity: csr_read, csr_write and ufmwrite are never high together. Only one CSR access per cycle.
- A start pulse while busy is ignored; data is not re-captured.
- NUM_WORDS=1: a single data write, then lock.
- Address arithmetic is modulo 2^ADDR_W.

Test Plan:
- ERASE_EN=1, NUM_WORDS=6, BASE_ADDR=0, words 0x11111111..0x66666666, status idle after 3 busy polls, success bits set -> CSR writes CTRL_ERASE, CTRL_OPEN, six data writes at addresses 0..5 in order, then CTRL_LOCK; done=1, words_written=6, err_code=00.
- waitrequest held high for 5 cycles on word 2 -> ufmwrite, write_addr=2 and writedata stay stable for all 5 cycles; exactly one transfer completes.
- Erase status returns idle with bit4=0 -> error=1, err_code=01, zero data writes issued, no lock write.
- Word 3 status returns idle with bit3=0 -> CTRL_LOCK is written, then error=1, err_code=10, words_written=3.
- Status stuck at 10 with POLL_TIMEOUT=20 -> ERR within 21 cycles of DATA_POLL entry, err_code=11, lock write issued.
- Reset asserted mid-DATA_WR, then start again with ERASE_EN=0 and BASE_ADDR=0x10 -> all outputs return to reset values the next cycle; the new run writes 0x10..0x15, skips erase, and reaches done.

Source files
------------

// File: rtl/ufm_burst_writer.sv
// ufm_burst_writer: programs NUM_WORDS words into user flash, erasing first
// when ERASE_EN, polling CSR status after each op and re-protecting at end.
// Ports: start/data_words in; Avalon data port (ufmwrite, write_addr,
// writedata, waitrequest); CSR port (csr_addr/read/write/writedata/readdata);
// status out: busy, done, error, err_code, words_written.
module ufm_burst_writer #(
  parameter int                NUM_WORDS    = 6,
  parameter int                ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter bit                ERASE_EN     = 1'b1,
  parameter logic [31:0]       CTRL_OPEN    = 32'hF7FF_FFFF,
  parameter logic [31:0]       CTRL_ERASE   = 32'hF71F_FFFF,
  parameter logic [31:0]       CTRL_LOCK    = 32'hFFFF_FFFF,
  parameter int                POLL_TIMEOUT = 65535
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [NUM_WORDS*32-1:0] data_words,
  output logic                    ufmwrite,
  output logic [ADDR_W-1:0]       write_addr,
  output logic [31:0]             writedata,
  input  logic                    waitrequest,
  output logic                    csr_addr,
  output logic                    csr_read,
  output logic                    csr_write,
  output logic [31:0]             csr_writedata,
  input  logic [31:0]             csr_readdata,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [1:0]              err_code,
  output logic [8:0]              words_written
);

  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int TW = $clog2(POLL_TIMEOUT + 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);
  localparam logic [TW-1:0] TMAX = TW'(POLL_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ERASE_WR,
    S_ERASE_POLL,
    S_OPEN_WR,
    S_DATA_WR,
    S_DATA_POLL,
    S_LOCK_WR,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   words_q [NUM_WORDS];
  logic [IW-1:0] idx_q;
  logic [IW-1:0] idx_nxt;
  logic [TW-1:0] tcnt_q;
  logic          sample_q;
  logic          accept;
  logic          polling;
  logic          tmo;
  logic          st_idle;
  logic          last;
  logic          unused_rd;

  assign unused_rd = ^{csr_readdata[31:5], csr_readdata[2]};

  assign accept  = start && (state_q == S_IDLE ||
                             state_q == S_DONE ||
                             state_q == S_ERR);
  assign polling = (state_q == S_ERASE_POLL) ||
                   (state_q == S_DATA_POLL);
  // Timeout wins over a status sample landing in the same cycle.
  assign tmo     = polling && (tcnt_q == TMAX);
  // sample_q marks the cycle after csr_read, when readdata is valid.
  assign st_idle = sample_q && (csr_readdata[1:0] == 2'b00);
  assign last    = (idx_q == LAST);
  assign idx_nxt = idx_q + IW'(1);

  assign busy  = !(state_q == S_IDLE ||
                   state_q == S_DONE ||
                   state_q == S_ERR);
  assign done  = (state_q == S_DONE);
  assign error = (state_q == S_ERR);

  always_comb begin
    state_d       = state_q;
    ufmwrite      = 1'b0;
    csr_addr      = 1'b0;
    csr_read      = 1'b0;
    csr_write     = 1'b0;
    csr_writedata = '0;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start)
          state_d = ERASE_EN ? S_ERASE_WR : S_OPEN_WR;
      end
      S_ERASE_WR: begin
        csr_write     = 1'b1;
        csr_addr      = 1'b1;
        csr_writedata = CTRL_ERASE;
        state_d       = S_ERASE_POLL;
      end
      S_OPEN_WR: begin
        csr_write     = 1'b1;
        csr_addr      = 1'b1;
        csr_writedata = CTRL_OPEN;
        state_d       = S_DATA_WR;
      end
      S_ERASE_POLL: begin
        csr_read = !sample_q && !tmo;
        if (tmo)
          state_d = S_LOCK_WR;
        else if (st_idle)
          state_d = csr_readdata[4] ? S_OPEN_WR : S_ERR;
      end
      S_DATA_WR: begin
        ufmwrite = 1'b1;
        if (!waitrequest)
          state_d = S_DATA_POLL;
      end
      S_DATA_POLL: begin
        csr_read = !sample_q && !tmo;
        if (tmo)
          state_d = S_LOCK_WR;
        else if (st_idle)
          state_d = (csr_readdata[3] && !last) ?
                    S_DATA_WR : S_LOCK_WR;
      end
      S_LOCK_WR: begin
        csr_write     = 1'b1;
        csr_addr      = 1'b1;
        csr_writedata = CTRL_LOCK;
        state_d = (err_code != 2'b00) ? S_ERR : S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      tcnt_q        <= '0;
      sample_q      <= 1'b0;
      idx_q         <= '0;
      err_code      <= 2'b00;
      words_written <= '0;
      write_addr    <= BASE_ADDR;
      writedata     <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        tcnt_q   <= '0;
        sample_q <= 1'b0;
      end else if (polling) begin
        tcnt_q   <= tcnt_q + TW'(1);
        sample_q <= !sample_q;
      end
      if (accept) begin
        idx_q         <= '0;
        err_code      <= 2'b00;
        words_written <= '0;
        write_addr    <= BASE_ADDR;
        writedata     <= data_words[31:0];
      end
      if (tmo) begin
        err_code <= 2'b11;
      end else if (state_q == S_ERASE_POLL && st_idle) begin
        if (!csr_readdata[4])
          err_code <= 2'b01;
      end else if (state_q == S_DATA_POLL && st_idle) begin
        if (!csr_readdata[3]) begin
          err_code <= 2'b10;
        end else begin
          words_written <= words_written + 9'd1;
          if (!last) begin
            idx_q      <= idx_nxt;
            write_addr <= write_addr + ADDR_W'(1);
            writedata  <= words_q[idx_nxt];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !reset) begin
      for (int i = 0; i < NUM_WORDS; i++)
        words_q[i] <= data_words[32*i +: 32];
    end
  end

endmodule

// File: tb/tb_ufm_burst_writer.sv
// Directed bench for ufm_burst_writer: flash responder model plus an
// expected-transaction queue checked against observed bus writes.
module tb_ufm_burst_writer;

  localparam logic [31:0] C_OPEN  = 32'hF7FF_FFFF;
  localparam logic [31:0] C_ERASE = 32'hF71F_FFFF;
  localparam logic [31:0] C_LOCK  = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, start_a, start_b, sel;
  logic         waitrequest;
  logic [191:0] data_words;
  logic [31:0]  csr_readdata;

  logic        a_uw, a_ca, a_cr, a_cw, a_busy, a_done, a_err;
  logic [15:0] a_wa;
  logic [31:0] a_wd, a_cwd;
  logic [1:0]  a_ec;
  logic [8:0]  a_ww;
  logic        b_uw, b_ca, b_cr, b_cw, b_busy, b_done, b_err;
  logic [15:0] b_wa;
  logic [31:0] b_wd, b_cwd;
  logic [1:0]  b_ec;
  logic [8:0]  b_ww;

  logic        m_uw, m_ca, m_cr, m_cw, m_done, m_err;
  logic [15:0] m_wa;
  logic [31:0] m_wd, m_cwd;

  assign m_uw   = sel ? b_uw   : a_uw;
  assign m_ca   = sel ? b_ca   : a_ca;
  assign m_cr   = sel ? b_cr   : a_cr;
  assign m_cw   = sel ? b_cw   : a_cw;
  assign m_done = sel ? b_done : a_done;
  assign m_err  = sel ? b_err  : a_err;
  assign m_wa   = sel ? b_wa   : a_wa;
  assign m_wd   = sel ? b_wd   : a_wd;
  assign m_cwd  = sel ? b_cwd  : a_cwd;

  ufm_burst_writer #(
    .NUM_WORDS(6), .ADDR_W(16), .BASE_ADDR(16'h0000),
    .ERASE_EN(1'b1), .POLL_TIMEOUT(20)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .data_words(data_words),
    .ufmwrite(a_uw), .write_addr(a_wa), .writedata(a_wd),
    .waitrequest(waitrequest),
    .csr_addr(a_ca), .csr_read(a_cr), .csr_write(a_cw),
    .csr_writedata(a_cwd), .csr_readdata(csr_readdata),
    .busy(a_busy), .done(a_done), .error(a_err),
    .err_code(a_ec), .words_written(a_ww)
  );

  ufm_burst_writer #(
    .NUM_WORDS(6), .ADDR_W(16), .BASE_ADDR(16'h0010),
    .ERASE_EN(1'b0), .POLL_TIMEOUT(20)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .data_words(data_words),
    .ufmwrite(b_uw), .write_addr(b_wa), .writedata(b_wd),
    .waitrequest(waitrequest),
    .csr_addr(b_ca), .csr_read(b_cr), .csr_write(b_cw),
    .csr_writedata(b_cwd), .csr_readdata(csr_readdata),
    .busy(b_busy), .done(b_done), .error(b_err),
    .err_code(b_ec), .words_written(b_ww)
  );

  int checks = 0;
  int errors = 0;

  int busy_polls, fail_word, stuck_word, stall_word, stall_len;
  bit erase_ok;

  int          busy_left, wr_idx, stall_cnt;
  logic [1:0]  busy_code;
  logic [31:0] idle_stat;
  logic        stuck_q;

  assign waitrequest = m_uw && (wr_idx == stall_word) &&
                       (stall_cnt < stall_len);

  always @(posedge clk) begin
    if (reset) begin
      busy_left    <= 0;
      wr_idx       <= 0;
      stall_cnt    <= 0;
      stuck_q      <= 1'b0;
      busy_code    <= 2'b00;
      idle_stat    <= '0;
      csr_readdata <= '0;
    end else begin
      if (m_cw && m_ca && m_cwd == C_ERASE) begin
        busy_left <= busy_polls;
        busy_code <= 2'b01;
        idle_stat <= erase_ok ? 32'h10 : 32'h0;
        stuck_q   <= 1'b0;
      end
      if (m_cw && m_ca && m_cwd == C_OPEN)
        wr_idx <= 0;
      if (m_uw && waitrequest)
        stall_cnt <= stall_cnt + 1;
      if (m_uw && !waitrequest) begin
        busy_left <= busy_polls;
        busy_code <= 2'b10;
        idle_stat <= (wr_idx == fail_word) ? 32'h0 : 32'h8;
        stuck_q   <= (wr_idx == stuck_word);
        wr_idx    <= wr_idx + 1;
        stall_cnt <= 0;
      end
      if (m_cr) begin
        if (stuck_q || busy_left > 0) begin
          csr_readdata <= {30'b0, busy_code};
          if (busy_left > 0)
            busy_left <= busy_left - 1;
        end else begin
          csr_readdata <= idle_stat;
        end
      end
    end
  end

  logic [49:0] exp_q[$];

  function automatic logic [49:0] tx(input logic [1:0] k,
                                     input logic [15:0] a,
                                     input logic [31:0] d);
    return {k, a, d};
  endfunction

  task automatic push(input logic [1:0] k, input logic [15:0] a,
                      input logic [31:0] d);
    exp_q.push_back(tx(k, a, d));
  endtask

  task automatic got(input string tag, input logic [49:0] t);
    logic [49:0] e;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL %s unexpected observed=%h expected=none", tag, t);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      assert (t === e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, t, e);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int          stall_cyc = 0;
  int          stall_bad = 0;
  logic        prev_stall = 1'b0;
  logic [47:0] prev_aw = '0;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (m_cw)
        got("csr_wr", tx(2'd1, {15'b0, m_ca}, m_cwd));
      if (m_uw && !waitrequest)
        got("data_wr", tx(2'd2, m_wa, m_wd));
      if (m_uw || m_cr || m_cw) begin
        checks++;
        assert ($countones({m_uw, m_cr, m_cw}) <= 1) else begin
          errors++;
          $error("FAIL exclusive observed=%b expected=onehot",
                 {m_uw, m_cr, m_cw});
        end
      end
      if (prev_stall) begin
        checks++;
        assert (m_uw && {m_wa, m_wd} === prev_aw) else begin
          errors++;
          stall_bad++;
          $error("FAIL stall_hold observed=%h expected=%h",
                 {m_uw, m_wa, m_wd}, {1'b1, prev_aw});
        end
      end
      if (m_uw && waitrequest)
        stall_cyc++;
      prev_stall = m_uw && waitrequest;
      prev_aw    = {m_wa, m_wd};
    end
  end

  task automatic pulse(input bit b);
    if (b) start_b = 1'b1;
    else   start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int cyc;
    cyc = 0;
    while (!(m_done || m_err) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    assert (cyc < 2000) else begin
      errors++;
      $error("FAIL %s_end observed=%0d cycles expected=<2000", tag, cyc);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int s0;
    int b0;
    logic [31:0] w;
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
    data_words = '0;
    busy_polls = 3; erase_ok = 1'b1;
    fail_word = -1; stuck_word = -1;
    stall_word = 2; stall_len = 0;
    repeat (3) @(negedge clk);

    chk("rst_strobes", {a_uw, a_cr, a_cw}, 0);
    chk("rst_flags", {a_busy, a_done, a_err, a_ec, a_ww}, 0);
    chk("rst_addr", a_wa, 0);
    chk("rst_wdata", a_wd, 0);
    chk("rst_b_addr", b_wa, 16'h10);
    reset = 1'b0;
    @(negedge clk);

    // Full run with a five-cycle stall on word 2.
    for (int i = 0; i < 6; i++)
      data_words[32*i +: 32] = 32'h1111_1111 * (i + 1);
    push(2'd1, 16'd1, C_ERASE);
    push(2'd1, 16'd1, C_OPEN);
    for (int i = 0; i < 6; i++)
      push(2'd2, 16'(i), 32'h1111_1111 * (i + 1));
    push(2'd1, 16'd1, C_LOCK);
    stall_len = 5;
    s0 = stall_cyc;
    b0 = stall_bad;
    pulse(1'b0);
    chk("run1_busy", a_busy, 1);
    wait_end("run1");
    chk("run1_done", {a_done, a_err}, 2'b10);
    chk("run1_ec", a_ec, 0);
    chk("run1_ww", a_ww, 6);
    chk("run1_qempty", exp_q.size(), 0);
    chk("run1_stall_cyc", stall_cyc - s0, 5);
    chk("run1_stall_bad", stall_bad - b0, 0);
    stall_len = 0;

    // Erase reports failure.
    erase_ok = 1'b0;
    push(2'd1, 16'd1, C_ERASE);
    pulse(1'b0);
    wait_end("erase_fail");
    repeat (4) @(negedge clk);
    chk("efail_flags", {a_done, a_err, a_busy}, 3'b010);
    chk("efail_ec", a_ec, 2'b01);
    chk("efail_ww", a_ww, 0);
    chk("efail_qempty", exp_q.size(), 0);
    erase_ok = 1'b1;

    // Word 3 write reports failure.
    fail_word = 3;
    push(2'd1, 16'd1, C_ERASE);
    push(2'd1, 16'd1, C_OPEN);
    for (int i = 0; i < 4; i++)
      push(2'd2, 16'(i), 32'h1111_1111 * (i + 1));
    push(2'd1, 16'd1, C_LOCK);
    pulse(1'b0);
    wait_end("wfail");
    chk("wfail_flags", {a_done, a_err}, 2'b01);
    chk("wfail_ec", a_ec, 2'b10);
    chk("wfail_ww", a_ww, 3);
    chk("wfail_qempty", exp_q.size(), 0);
    fail_word = -1;

    // Status stuck busy-write after word 1.
    stuck_word = 1;
    push(2'd1, 16'd1, C_ERASE);
    push(2'd1, 16'd1, C_OPEN);
    for (int i = 0; i < 2; i++)
      push(2'd2, 16'(i), 32'h1111_1111 * (i + 1));
    push(2'd1, 16'd1, C_LOCK);
    pulse(1'b0);
    cyc = 0;
    while (!(a_uw && !waitrequest && a_wa == 16'd1) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("tmo_reach_w1", cyc < 500, 1);
    cyc = 0;
    while (!a_err && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("tmo_window", (cyc - 1 >= 20) && (cyc - 1 <= 21), 1);
    chk("tmo_ec", a_ec, 2'b11);
    chk("tmo_ww", a_ww, 1);
    chk("tmo_qempty", exp_q.size(), 0);
    stuck_word = -1;

    // Reset while word 2 is held by waitrequest.
    stall_word = 2;
    stall_len  = 1000;
    push(2'd1, 16'd1, C_ERASE);
    push(2'd1, 16'd1, C_OPEN);
    for (int i = 0; i < 2; i++)
      push(2'd2, 16'(i), 32'h1111_1111 * (i + 1));
    pulse(1'b0);
    cyc = 0;
    while (!(a_uw && a_wa == 16'd2) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    chk("abort_held", {a_uw, waitrequest, a_wa}, {2'b11, 16'd2});
    reset = 1'b1;
    @(negedge clk);
    chk("abort_strobes", {a_uw, a_cr, a_cw}, 0);
    chk("abort_flags", {a_busy, a_done, a_err, a_ec, a_ww}, 0);
    chk("abort_addr", a_wa, 0);
    chk("abort_wdata", a_wd, 0);
    chk("abort_qempty", exp_q.size(), 0);
    @(negedge clk);
    reset = 1'b0;
    stall_len = 0;
    repeat (2) @(negedge clk);

    // No-erase instance at base 0x10; a second start mid-run is ignored.
    sel = 1'b1;
    for (int i = 0; i < 6; i++)
      data_words[32*i +: 32] = 32'hA000_0000 + i;
    push(2'd1, 16'd1, C_OPEN);
    for (int i = 0; i < 6; i++)
      push(2'd2, 16'h10 + 16'(i), 32'hA000_0000 + i);
    push(2'd1, 16'd1, C_LOCK);
    pulse(1'b1);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      w = 32'hDEAD_0000 + i;
      data_words[32*i +: 32] = w;
    end
    pulse(1'b1);
    wait_end("runb");
    chk("runb_flags", {b_done, b_err, b_busy}, 3'b100);
    chk("runb_ec", b_ec, 0);
    chk("runb_ww", b_ww, 6);
    chk("runb_qempty", exp_q.size(), 0);
    chk("runb_a_idle", {a_busy, a_uw, a_cw, a_cr}, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
